// File: rtl/msi_cache_sa_if.sv
// msi_cache_sa_if: CPU lookup/write and snoop port bundle for msi_cache_sa.
// State encoding on the 2-bit state fields: 0 = INVALID, 1 = SHARED, 2 = MODIFIED.
interface msi_cache_sa_if #(
  parameter int ADDR_W   = 11,
  parameter int SET_BITS = 6,
  parameter int LINE_W   = 64
);
  logic                       cpu_re;
  logic                       cpu_we;
  logic [ADDR_W-1:0]          cpu_addr;
  logic [LINE_W-1:0]          cpu_wr_data;
  logic [1:0]                 cpu_wstate;
  logic                       cpu_rvalid;
  logic                       cpu_hit;
  logic [1:0]                 cpu_rstate;
  logic [LINE_W-1:0]          cpu_rd_data;
  logic                       victim_valid;
  logic                       victim_dirty;
  logic [ADDR_W-SET_BITS-1:0] victim_tag;
  logic [LINE_W-1:0]          victim_data;
  logic                       snp_valid;
  logic                       snp_inv;
  logic [ADDR_W-1:0]          snp_addr;
  logic                       snp_rvalid;
  logic                       snp_hit;
  logic                       snp_dirty;
  logic [LINE_W-1:0]          snp_data;
  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wr_data, cpu_wstate, snp_valid, snp_inv, snp_addr,
    input  cpu_rvalid, cpu_hit, cpu_rstate, cpu_rd_data, victim_valid, victim_dirty,
           victim_tag, victim_data, snp_rvalid, snp_hit, snp_dirty, snp_data
  );
  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wr_data, cpu_wstate, snp_valid, snp_inv, snp_addr,
    output cpu_rvalid, cpu_hit, cpu_rstate, cpu_rd_data, victim_valid, victim_dirty,
           victim_tag, victim_data, snp_rvalid, snp_hit, snp_dirty, snp_data
  );
endinterface

// File: rtl/msi_cache_sa.sv
// msi_cache_sa: N-way set-associative MSI cache array with registered CPU lookups,
// true-LRU victim selection and a snoop port; CPU writes win same-line collisions.
module msi_cache_sa #(
  parameter int ADDR_W   = 11,
  parameter int SET_BITS = 6,
  parameter int WAYS     = 2,
  parameter int LINE_W   = 64
) (
  input logic           clk,
  input logic           rst_n,
  msi_cache_sa_if.slave bus
);
  localparam int TAG_W = ADDR_W - SET_BITS;
  localparam int SETS  = 1 << SET_BITS;
  localparam int AW    = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam logic [1:0] INVALID = 2'd0, SHARED = 2'd1, MODIFIED = 2'd2;

  logic [1:0]          state_q [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]   data_q  [SETS][WAYS];
  logic [SET_BITS-1:0] c_set, s_set;
  logic [TAG_W-1:0]    c_tag, s_tag;
  logic                c_hit, s_hit, inv_found, miss_vic;
  logic [AW-1:0]       c_way, s_way, inv_way, lru_way, vic_way, tgt_way;

  assign c_set = bus.cpu_addr[SET_BITS-1:0];
  assign c_tag = bus.cpu_addr[ADDR_W-1:SET_BITS];
  assign s_set = bus.snp_addr[SET_BITS-1:0];
  assign s_tag = bus.snp_addr[ADDR_W-1:SET_BITS];

  // Downward scan so the lowest-index invalid way is the one left selected
  always_comb begin
    c_hit = 1'b0;
    s_hit = 1'b0;
    inv_found = 1'b0;
    c_way = '0;
    s_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (state_q[c_set][w] != INVALID && tag_q[c_set][w] == c_tag) begin
        c_hit = 1'b1;
        c_way = AW'(w);
      end
      if (state_q[s_set][w] != INVALID && tag_q[s_set][w] == s_tag) begin
        s_hit = 1'b1;
        s_way = AW'(w);
      end
      if (state_q[c_set][w] == INVALID) begin
        inv_found = 1'b1;
        inv_way = AW'(w);
      end
    end
  end

  assign vic_way  = inv_found ? inv_way : lru_way;
  assign tgt_way  = c_hit ? c_way : vic_way;
  assign miss_vic = bus.cpu_re && !c_hit && !inv_found;

  generate
    if (WAYS > 1) begin : g_lru
      logic [AW-1:0] age_q [SETS][WAYS];
      logic [AW-1:0] acc_way;
      assign acc_way = bus.cpu_we ? tgt_way : c_way;
      always_comb begin
        lru_way = '0;
        for (int w = 0; w < WAYS; w++)
          if (age_q[c_set][w] == AW'(WAYS - 1)) lru_way = AW'(w);
      end
      // Accessed way becomes age 0; only ways younger than it age by one
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
        end else if ((bus.cpu_re && c_hit) || bus.cpu_we) begin
          for (int w = 0; w < WAYS; w++)
            if (AW'(w) == acc_way) age_q[c_set][w] <= '0;
            else if (age_q[c_set][w] < age_q[c_set][acc_way]) age_q[c_set][w] <= age_q[c_set][w] + 1'b1;
        end
    end else begin : g_no_lru
      assign lru_way = '0;
    end
  endgenerate

  // CPU write is applied after the snoop update so it wins on the same way
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) state_q[s][w] <= INVALID;
    end else begin
      if (bus.snp_valid && s_hit)
        state_q[s_set][s_way] <= bus.snp_inv ? INVALID :
                                 (state_q[s_set][s_way] == MODIFIED ? SHARED : state_q[s_set][s_way]);
      if (bus.cpu_we) state_q[c_set][tgt_way] <= bus.cpu_wstate;
    end

  always_ff @(posedge clk)
    if (bus.cpu_we) begin
      tag_q[c_set][tgt_way]  <= c_tag;
      data_q[c_set][tgt_way] <= bus.cpu_wr_data;
    end

  logic                cpu_rvalid_q, cpu_hit_q, victim_valid_q, victim_dirty_q;
  logic                snp_rvalid_q, snp_hit_q, snp_dirty_q;
  logic [1:0]          cpu_rstate_q;
  logic [TAG_W-1:0]    victim_tag_q;
  logic [LINE_W-1:0]   cpu_rd_data_q, victim_data_q, snp_data_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cpu_rvalid_q   <= 1'b0;
      cpu_hit_q      <= 1'b0;
      cpu_rstate_q   <= INVALID;
      cpu_rd_data_q  <= '0;
      victim_valid_q <= 1'b0;
      victim_dirty_q <= 1'b0;
      victim_tag_q   <= '0;
      victim_data_q  <= '0;
      snp_rvalid_q   <= 1'b0;
      snp_hit_q      <= 1'b0;
      snp_dirty_q    <= 1'b0;
      snp_data_q     <= '0;
    end else begin
      cpu_rvalid_q   <= bus.cpu_re;
      cpu_hit_q      <= bus.cpu_re && c_hit;
      victim_valid_q <= miss_vic;
      victim_dirty_q <= miss_vic && state_q[c_set][lru_way] == MODIFIED;
      victim_tag_q   <= miss_vic ? tag_q[c_set][lru_way] : '0;
      victim_data_q  <= miss_vic ? data_q[c_set][lru_way] : '0;
      if (bus.cpu_re) cpu_rstate_q <= c_hit ? state_q[c_set][c_way] : INVALID;
      if (bus.cpu_re && c_hit) cpu_rd_data_q <= data_q[c_set][c_way];
      snp_rvalid_q   <= bus.snp_valid;
      snp_hit_q      <= bus.snp_valid && s_hit;
      snp_dirty_q    <= bus.snp_valid && s_hit && state_q[s_set][s_way] == MODIFIED;
      if (bus.snp_valid && s_hit) snp_data_q <= data_q[s_set][s_way];
    end

  assign bus.cpu_rvalid   = cpu_rvalid_q;
  assign bus.cpu_hit      = cpu_hit_q;
  assign bus.cpu_rstate   = cpu_rstate_q;
  assign bus.cpu_rd_data  = cpu_rd_data_q;
  assign bus.victim_valid = victim_valid_q;
  assign bus.victim_dirty = victim_dirty_q;
  assign bus.victim_tag   = victim_tag_q;
  assign bus.victim_data  = victim_data_q;
  assign bus.snp_rvalid   = snp_rvalid_q;
  assign bus.snp_hit      = snp_hit_q;
  assign bus.snp_dirty    = snp_dirty_q;
  assign bus.snp_data     = snp_data_q;
endmodule

// File: tb/tb_msi_cache_sa.sv
// tb_msi_cache_sa: directed and randomized checks of msi_cache_sa against a
// recency-list cache model kept in the bench.
module tb_msi_cache_sa;
  localparam int ADDR_W = 11, SET_BITS = 6, WAYS = 2, LINE_W = 64, SETS = 64;
  localparam logic [1:0] INV = 2'd0, SHR = 2'd1, MOD = 2'd2;
  localparam logic [63:0] DA = 64'hAAAA_0000_1111_0041, DB = 64'hBBBB_2222_3333_0081, DC = 64'hCCCC_4444_5555_0041;

  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;

  msi_cache_sa_if #(.ADDR_W(ADDR_W), .SET_BITS(SET_BITS), .LINE_W(LINE_W)) bus();
  msi_cache_sa #(.ADDR_W(ADDR_W), .SET_BITS(SET_BITS), .WAYS(WAYS), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [1:0]  mst   [SETS][WAYS];
  logic [4:0]  mtag  [SETS][WAYS];
  logic [63:0] mdata [SETS][WAYS];
  int          ord   [SETS][WAYS];
  logic        e_hit, e_vv, e_vd, e_shit, e_sdirty;
  logic [1:0]  e_rstate;
  logic [4:0]  e_vt;
  logic [63:0] e_rd, e_vdata, e_sdata;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mst[s][w] = INV;
        ord[s][w] = w;
      end
  endtask

  function automatic int find(input logic [10:0] a);
    int f = -1, n = 0;
    for (int w = 0; w < WAYS; w++)
      if (mst[a[5:0]][w] != INV && mtag[a[5:0]][w] == a[10:6]) begin
        f = w;
        n++;
      end
    assert (n <= 1) else $error("FAIL multi_match: %0d ways match addr %h", n, a);
    return f;
  endfunction

  function automatic int victim(input logic [5:0] s);
    for (int w = 0; w < WAYS; w++) if (mst[s][w] == INV) return w;
    return ord[s][WAYS-1];
  endfunction

  task automatic touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < WAYS; i++) if (ord[s][i] == w) p = i;
    for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
    ord[s][0] = w;
  endtask

  // Predicts responses from pre-edge model state, applies one clock edge, then updates the model
  task automatic drive(input logic re, we, input logic [10:0] a, input logic [63:0] d,
                       input logic [1:0] ws, input logic sv, si, input logic [10:0] sa);
    int s = int'(a[5:0]);
    int ss = int'(sa[5:0]);
    int h = find(a);
    int v = victim(a[5:0]);
    int sh = find(sa);
    int tw = h >= 0 ? h : v;
    e_hit = re && h >= 0;
    if (re) e_rstate = h >= 0 ? mst[s][h] : INV;
    if (e_hit) e_rd = mdata[s][h];
    e_vv = re && h < 0 && mst[s][v] != INV;
    e_vd = e_vv && mst[s][v] == MOD;
    e_vt = e_vv ? mtag[s][v] : 5'd0;
    e_vdata = e_vv ? mdata[s][v] : 64'd0;
    e_shit = sv && sh >= 0;
    e_sdirty = e_shit && mst[ss][sh] == MOD;
    if (e_shit) e_sdata = mdata[ss][sh];
    bus.cpu_re = re; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wr_data = d; bus.cpu_wstate = ws;
    bus.snp_valid = sv; bus.snp_inv = si; bus.snp_addr = sa;
    @(posedge clk); #1;
    bus.cpu_re = 1'b0; bus.cpu_we = 1'b0; bus.snp_valid = 1'b0;
    if (e_shit) mst[ss][sh] = si ? INV : (mst[ss][sh] == MOD ? SHR : mst[ss][sh]);
    if (we) begin
      mst[s][tw] = ws;
      mtag[s][tw] = a[10:6];
      mdata[s][tw] = d;
    end
    if (we || e_hit) touch(s, tw);
  endtask

  task automatic test_reset();
    checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", bus.cpu_rvalid); end
    checks++; if (bus.cpu_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", bus.cpu_hit); end
    checks++; if (bus.cpu_rstate !== INV) begin errors++; $display("FAIL reset_rstate: got %0d want 0", bus.cpu_rstate); end
    checks++; if (bus.victim_valid !== 1'b0) begin errors++; $display("FAIL reset_vvalid: got %b want 0", bus.victim_valid); end
    checks++; if (bus.snp_rvalid !== 1'b0) begin errors++; $display("FAIL reset_snp_rvalid: got %b want 0", bus.snp_rvalid); end
    drive(1, 0, 11'h041, 64'd0, INV, 0, 0, 11'h0);
    checks++; if (bus.cpu_rvalid !== 1'b1) begin errors++; $display("FAIL first_rvalid: got %b want 1", bus.cpu_rvalid); end
    checks++; if (bus.cpu_hit !== 1'b0) begin errors++; $display("FAIL first_hit: got %b want 0", bus.cpu_hit); end
    checks++; if (bus.victim_valid !== 1'b0) begin errors++; $display("FAIL first_vvalid: got %b want 0", bus.victim_valid); end
    drive(0, 0, 11'h0, 64'd0, INV, 0, 0, 11'h0);
    checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse: got %b want 0", bus.cpu_rvalid); end
  endtask

  task automatic test_fill_lru();
    drive(0, 1, 11'h041, DA, MOD, 0, 0, 11'h0);
    drive(0, 1, 11'h081, DB, SHR, 0, 0, 11'h0);
    drive(1, 0, 11'h041, 64'd0, INV, 0, 0, 11'h0);
    checks++; if (bus.cpu_hit !== 1'b1) begin errors++; $display("FAIL fill_hit: got %b want 1", bus.cpu_hit); end
    checks++; if (bus.cpu_rstate !== MOD) begin errors++; $display("FAIL fill_rstate: got %0d want 2", bus.cpu_rstate); end
    checks++; if (bus.cpu_rd_data !== DA) begin errors++; $display("FAIL fill_data: got %h want %h", bus.cpu_rd_data, DA); end
    drive(1, 0, 11'h0C1, 64'd0, INV, 0, 0, 11'h0);
    checks++; if (bus.cpu_hit !== 1'b0) begin errors++; $display("FAIL lru_hit: got %b want 0", bus.cpu_hit); end
    checks++; if (bus.victim_valid !== 1'b1) begin errors++; $display("FAIL lru_vvalid: got %b want 1", bus.victim_valid); end
    checks++; if (bus.victim_tag !== 5'h02) begin errors++; $display("FAIL lru_vtag: got %h want 02", bus.victim_tag); end
    checks++; if (bus.victim_dirty !== 1'b0) begin errors++; $display("FAIL lru_vdirty: got %b want 0", bus.victim_dirty); end
    checks++; if (bus.victim_data !== DB) begin errors++; $display("FAIL lru_vdata: got %h want %h", bus.victim_data, DB); end
  endtask

  task automatic test_snoop();
    drive(0, 0, 11'h0, 64'd0, INV, 1, 0, 11'h041);
    checks++; if (bus.snp_rvalid !== 1'b1) begin errors++; $display("FAIL snp_rvalid: got %b want 1", bus.snp_rvalid); end
    checks++; if (bus.snp_hit !== 1'b1) begin errors++; $display("FAIL snp_rd_hit: got %b want 1", bus.snp_hit); end
    checks++; if (bus.snp_dirty !== 1'b1) begin errors++; $display("FAIL snp_rd_dirty: got %b want 1", bus.snp_dirty); end
    checks++; if (bus.snp_data !== DA) begin errors++; $display("FAIL snp_rd_data: got %h want %h", bus.snp_data, DA); end
    drive(1, 0, 11'h041, 64'd0, INV, 0, 0, 11'h0);
    checks++; if (bus.cpu_rstate !== SHR) begin errors++; $display("FAIL downgrade_state: got %0d want 1", bus.cpu_rstate); end
    drive(0, 0, 11'h0, 64'd0, INV, 1, 1, 11'h041);
    checks++; if (bus.snp_hit !== 1'b1) begin errors++; $display("FAIL snp_inv_hit: got %b want 1", bus.snp_hit); end
    checks++; if (bus.snp_dirty !== 1'b0) begin errors++; $display("FAIL snp_inv_dirty: got %b want 0", bus.snp_dirty); end
    drive(1, 0, 11'h041, 64'd0, INV, 0, 0, 11'h0);
    checks++; if (bus.cpu_hit !== 1'b0) begin errors++; $display("FAIL inv_miss: got %b want 0", bus.cpu_hit); end
    checks++; if (bus.cpu_rstate !== INV) begin errors++; $display("FAIL inv_rstate: got %0d want 0", bus.cpu_rstate); end
  endtask

  task automatic test_collision();
    drive(0, 1, 11'h041, DA, SHR, 0, 0, 11'h0);
    drive(0, 1, 11'h041, DC, MOD, 1, 1, 11'h041);
    checks++; if (bus.snp_hit !== 1'b1) begin errors++; $display("FAIL coll_snp_hit: got %b want 1", bus.snp_hit); end
    checks++; if (bus.snp_dirty !== 1'b0) begin errors++; $display("FAIL coll_snp_dirty: got %b want 0", bus.snp_dirty); end
    drive(1, 0, 11'h041, 64'd0, INV, 0, 0, 11'h0);
    checks++; if (bus.cpu_hit !== 1'b1) begin errors++; $display("FAIL coll_hit: got %b want 1", bus.cpu_hit); end
    checks++; if (bus.cpu_rstate !== MOD) begin errors++; $display("FAIL coll_state: got %0d want 2", bus.cpu_rstate); end
    checks++; if (bus.cpu_rd_data !== DC) begin errors++; $display("FAIL coll_data: got %h want %h", bus.cpu_rd_data, DC); end
  endtask

  task automatic test_reset_inflight();
    bus.cpu_re = 1'b1; bus.cpu_addr = 11'h041;
    @(posedge clk); #1;
    bus.cpu_re = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL inflight_rvalid: got %b want 0", bus.cpu_rvalid); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid: got %b want 0", bus.cpu_rvalid); end
    model_reset();
    drive(1, 0, 11'h041, 64'd0, INV, 0, 0, 11'h0);
    checks++; if (bus.cpu_hit !== 1'b0) begin errors++; $display("FAIL post_reset_hit041: got %b want 0", bus.cpu_hit); end
    drive(1, 0, 11'h081, 64'd0, INV, 0, 0, 11'h0);
    checks++; if (bus.cpu_hit !== 1'b0) begin errors++; $display("FAIL post_reset_hit081: got %b want 0", bus.cpu_hit); end
    checks++; if (bus.victim_valid !== 1'b0) begin errors++; $display("FAIL post_reset_vvalid: got %b want 0", bus.victim_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic re = ($urandom_range(0, 1) == 1);
      logic we = ($urandom_range(0, 2) == 0);
      logic sv = ($urandom_range(0, 2) == 0);
      logic si = ($urandom_range(0, 1) == 1);
      logic [10:0] a = {3'b000, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
      logic [10:0] sa = {3'b000, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
      logic [63:0] d = {$urandom, $urandom};
      logic [1:0] ws = 2'($urandom_range(0, 2));
      drive(re, we, a, d, ws, sv, si, sa);
      checks++; if (bus.cpu_rvalid !== re) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", n, bus.cpu_rvalid, re); end
      checks++; if (bus.cpu_hit !== e_hit) begin errors++; $display("FAIL rnd_hit[%0d]: got %b want %b", n, bus.cpu_hit, e_hit); end
      if (re) begin
        checks++; if (bus.cpu_rstate !== e_rstate) begin errors++; $display("FAIL rnd_rstate[%0d]: got %0d want %0d", n, bus.cpu_rstate, e_rstate); end
      end
      if (e_hit) begin
        checks++; if (bus.cpu_rd_data !== e_rd) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, bus.cpu_rd_data, e_rd); end
      end
      checks++; if (bus.victim_valid !== e_vv) begin errors++; $display("FAIL rnd_vvalid[%0d]: got %b want %b", n, bus.victim_valid, e_vv); end
      checks++; if (bus.victim_dirty !== e_vd) begin errors++; $display("FAIL rnd_vdirty[%0d]: got %b want %b", n, bus.victim_dirty, e_vd); end
      checks++; if (bus.victim_tag !== e_vt) begin errors++; $display("FAIL rnd_vtag[%0d]: got %h want %h", n, bus.victim_tag, e_vt); end
      checks++; if (bus.victim_data !== e_vdata) begin errors++; $display("FAIL rnd_vdata[%0d]: got %h want %h", n, bus.victim_data, e_vdata); end
      checks++; if (bus.snp_rvalid !== sv) begin errors++; $display("FAIL rnd_snp_rvalid[%0d]: got %b want %b", n, bus.snp_rvalid, sv); end
      checks++; if (bus.snp_hit !== e_shit) begin errors++; $display("FAIL rnd_snp_hit[%0d]: got %b want %b", n, bus.snp_hit, e_shit); end
      checks++; if (bus.snp_dirty !== e_sdirty) begin errors++; $display("FAIL rnd_snp_dirty[%0d]: got %b want %b", n, bus.snp_dirty, e_sdirty); end
      if (e_shit) begin
        checks++; if (bus.snp_data !== e_sdata) begin errors++; $display("FAIL rnd_snp_data[%0d]: got %h want %h", n, bus.snp_data, e_sdata); end
      end
    end
  endtask

  initial begin
    bus.cpu_re = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wr_data = '0; bus.cpu_wstate = INV;
    bus.snp_valid = 1'b0; bus.snp_inv = 1'b0; bus.snp_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_fill_lru();
    test_snoop();
    test_collision();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/msi_cache_sa.md
Name: msi_cache_sa

Overview:
Parametrised N-way set-associative MSI cache array with a CPU port and a separate snoop port; the next generation of the direct-mapped MSI cache array.
- Fully synchronous: registered lookups, true-LRU replacement and victim reporting.
- Snoop-driven state downgrades (M->S) and invalidations, with defined priority on CPU/snoop collisions.
- Sits between the per-core cache controller FSM and the shared snoop bus.

Parameters:
ADDR_W, 11, line address width (word-offset LSBs already dropped)
SET_BITS, 6, log2(number of sets); index = addr[SET_BITS-1:0], tag = addr[ADDR_W-1:SET_BITS]
WAYS, 2, associativity; power of two, 1..8
LINE_W, 64, cache line width in bits

Ports:
clk  in  1  clock, all state changes on posedge
rst_n  in  1  asynchronous active-low reset
cpu_re  in  1  CPU lookup request
cpu_we  in  1  CPU line write (fill / update / evict)
cpu_addr  in  ADDR_W  CPU line address
cpu_wr_data  in  LINE_W  line to write
cpu_wstate  in  blk_state_t  state to write {INVALID,SHARED,MODIFIED}
cpu_rvalid  out  1  lookup result valid (1 cycle after cpu_re)
cpu_hit  out  1  tag match in a non-INVALID way
cpu_rstate  out  blk_state_t  state of hit line (INVALID on miss)
cpu_rd_data  out  LINE_W  hit line data
victim_valid  out  1  on miss: chosen victim way holds a valid line
victim_dirty  out  1  victim is MODIFIED (write-back required)
victim_tag  out  ADDR_W-SET_BITS  victim tag for write-back address
victim_data  out  LINE_W  victim line data
snp_valid  in  1  snoop request from bus
snp_inv  in  1  0 = BusRd (M->S), 1 = BusRdX/invalidate (->I)
snp_addr  in  ADDR_W  snooped line address
snp_rvalid  out  1  snoop response valid (1 cycle after snp_valid)
snp_hit  out  1  snooped line was present (non-INVALID) before update
snp_dirty  out  1  snooped line was MODIFIED; controller must supply snp_data
snp_data  out  LINE_W  snooped line data

Behaviour:
- Storage per way per set: state[1:0] (flops), tag, data.
- Reset (async, rst_n low):
  - All states INVALID.
  - LRU ages: way i = i, so way 0 is MRU and way WAYS-1 is LRU.
  - All outputs 0 / INVALID.
  - Tag and data are not reset.
  - Any in-flight lookup or snoop is discarded; no rvalid follows reset release.
- CPU lookup: cpu_re sampled at posedge T; at T+1, cpu_rvalid=1 for exactly one cycle.
  - cpu_hit / cpu_rstate / cpu_rd_data reflect the array contents before edge T updates.
  - At most one way may match; matching more than one way is a controller error (assertion in bench).
- Victim selection (on a lookup miss):
  - Lowest-index INVALID way if one exists (victim_valid=0); otherwise the LRU way (victim_valid=1, victim_dirty=(state==MODIFIED)).
  - On a hit, the victim_* outputs are 0.
- CPU write: cpu_we at posedge writes {cpu_wstate, tag, cpu_wr_data}. Target way:
  - the way whose valid tag matches, else
  - the victim way computed as above.
- LRU:
  - Per-set age counters, log2(WAYS) bits per way (true LRU).
  - A hit lookup or any cpu_we makes the accessed way age 0; ways younger than it increment.
  - Misses and snoops do not touch LRU.
  - WAYS=1: LRU logic is absent, victim is always way 0.
- cpu_re and cpu_we in the same cycle: write occurs; the lookup reports pre-write contents (read-old).
- Snoop:
  - snp_valid sampled at posedge T; at T+1, snp_rvalid=1 for one cycle with the pre-update snp_hit / snp_dirty / snp_data.
  - State update happens at edge T: snp_inv=0 → MODIFIED→SHARED, SHARED unchanged; snp_inv=1 → matching way→INVALID.
  - Snoop miss: no state change.
- Collision (same edge, cpu_we and snp_valid, same set and same tag): CPU write wins (the CPU holds the bus grant). Final state = cpu_wstate; the snoop response still reports pre-edge state.
- Different sets, or same set with different ways: both updates apply independently.
- cpu_re with snoop on the same line, same edge: the lookup returns pre-edge state; the snoop update lands afterwards.
- Outputs hold their last value when rvalid=0, except victim_* and hit flags, which are cleared.

Test Plan:
- Reset then cpu_re addr=0x041 → T+1: cpu_rvalid=1, cpu_hit=0, victim_valid=0 (way 0 invalid).
- WAYS=2: cpu_we 0x041 (M, data A), cpu_we 0x081 (S, data B), cpu_re 0x041 → hit, rstate=MODIFIED, rd_data=A. Then cpu_re 0x0C1 → miss, victim = way holding 0x081 (LRU), victim_tag=0x02, victim_dirty=0.
- Line 0x041 MODIFIED, snp_valid, snp_inv=0, addr 0x041 → snp_hit=1, snp_dirty=1, snp_data=A; later cpu_re shows SHARED.
- Line SHARED, snp_inv=1 → snp_hit=1, snp_dirty=0; following cpu_re is a miss.
- Same-edge cpu_we 0x041 (M, data C) and snp_inv=1 to 0x041 → final state MODIFIED, data C; snp_hit reflects prior state.
- Assert rst_n low for 1 cycle between cpu_re and the response edge → no cpu_rvalid; all lines INVALID after release.
